// File: rtl/conv1d_requant_pack.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_requant_pack
// Purpose  : int8 requantization of conv1d accumulators (bias, SRDHM, rounding
//            shift, offset, clamp) and 4-byte little-endian packing.
//            Optional macro REQUANT_PER_CHANNEL_EN: per-channel bias/mult/shift.
// Revision : 1.0
// ============================================================================
module conv1d_requant_pack #(
   parameter int BYTE_SIZE    = 8,
   parameter int INT32_SIZE   = 32,
   parameter int MAX_CHANNELS = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_we,
   input  logic [2:0]            cfg_addr,
   input  logic [6:0]            cfg_index,
   input  logic [INT32_SIZE-1:0] cfg_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INT32_SIZE-1:0] in_acc,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [INT32_SIZE-1:0] out_word,
   output logic [2:0]            out_bytes,
   output logic                  busy
);
   localparam logic [31:0] MULT_RST    = 32'h4000_0000;
   localparam logic [31:0] ACT_MIN_RST = 32'hFFFF_FF80;
   localparam logic [31:0] ACT_MAX_RST = 32'h0000_007F;
   localparam logic [31:0] INT_MIN     = 32'h8000_0000;
   localparam logic [63:0] NUDGE_POS   = 64'h0000_0000_4000_0000;
   localparam logic [63:0] NUDGE_NEG   = 64'hFFFF_FFFF_C000_0001;

`ifdef REQUANT_PER_CHANNEL_EN
   logic [MAX_CHANNELS-1:0][31:0] bias_q, bias_d, mult_q, mult_d;
   logic [MAX_CHANNELS-1:0][5:0]  shift_q, shift_d;
   logic [7:0] chan_cnt_q, chan_cnt_d;
   logic [6:0] ch_q, ch_d;
`else
   logic [31:0] bias_q, bias_d, mult_q, mult_d;
   logic [5:0]  shift_q, shift_d;
`endif
   logic [31:0] ofs_q, ofs_d, amin_q, amin_d, amax_q, amax_d;
   logic [31:0] sel_bias, sel_mult;
   logic [5:0]  sel_shift;

   logic        s1_v_q, s1_v_d, s1_last_q, s1_last_d;
   logic [31:0] s1_x_q, s1_x_d, s1_mult_q, s1_mult_d;
   logic [5:0]  s1_shift_q, s1_shift_d;
   logic        s2_v_q, s2_v_d, s2_last_q, s2_last_d, s2_sat_q, s2_sat_d;
   logic signed [63:0] s2_p_q, s2_p_d;
   logic [5:0]  s2_shift_q, s2_shift_d;
   logic        s3_v_q, s3_v_d, s3_last_q, s3_last_d;
   logic [31:0] s3_y_q, s3_y_d;
   logic [5:0]  s3_shift_q, s3_shift_d;
   logic        s4_v_q, s4_v_d, s4_last_q, s4_last_d;
   logic [BYTE_SIZE-1:0] s4_byte_q, s4_byte_d;
   logic [23:0] pack_q, pack_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_word_q, out_word_d;
   logic [2:0]  out_bytes_q, out_bytes_d;

   logic        en;
   logic [31:0] x, mask, thr, clamped, word;
   logic signed [63:0] xs, ms, t, q;
   logic signed [31:0] r, v;
   logic [5:0]  e;

`ifdef REQUANT_PER_CHANNEL_EN
   assign sel_bias  = bias_q[ch_q];
   assign sel_mult  = mult_q[ch_q];
   assign sel_shift = shift_q[ch_q];
   logic unused_ok;
   assign unused_ok = ^{q[63:32], clamped[31:8]};
`else
   assign sel_bias  = bias_q;
   assign sel_mult  = mult_q;
   assign sel_shift = shift_q;
   logic [31:0] unused_max_ch;
   logic        unused_ok;
   assign unused_max_ch = 32'(MAX_CHANNELS);
   assign unused_ok     = ^{q[63:32], clamped[31:8], cfg_index};
`endif

   always_comb begin
      bias_d = bias_q;
      mult_d = mult_q;
      shift_d = shift_q;
      ofs_d = ofs_q;
      amin_d = amin_q;
      amax_d = amax_q;
`ifdef REQUANT_PER_CHANNEL_EN
      chan_cnt_d = chan_cnt_q;
`endif
      if (cfg_we) begin
         case (cfg_addr)
`ifdef REQUANT_PER_CHANNEL_EN
            3'd0: bias_d[cfg_index]  = cfg_data;
            3'd1: mult_d[cfg_index]  = cfg_data;
            3'd2: shift_d[cfg_index] = cfg_data[5:0];
            3'd6: chan_cnt_d         = cfg_data[7:0];
`else
            3'd0: bias_d  = cfg_data;
            3'd1: mult_d  = cfg_data;
            3'd2: shift_d = cfg_data[5:0];
`endif
            3'd3: ofs_d  = cfg_data;
            3'd4: amin_d = cfg_data;
            3'd5: amax_d = cfg_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      en = !out_valid_q || out_ready;
      {s1_v_d, s1_last_d, s1_x_d, s1_mult_d, s1_shift_d} = {s1_v_q, s1_last_q, s1_x_q, s1_mult_q, s1_shift_q};
      {s2_v_d, s2_last_d, s2_sat_d, s2_p_d, s2_shift_d} = {s2_v_q, s2_last_q, s2_sat_q, s2_p_q, s2_shift_q};
      {s3_v_d, s3_last_d, s3_y_d, s3_shift_d} = {s3_v_q, s3_last_q, s3_y_q, s3_shift_q};
      {s4_v_d, s4_last_d, s4_byte_d} = {s4_v_q, s4_last_q, s4_byte_q};
      pack_d = pack_q;
      cnt_d = cnt_q;
      out_valid_d = out_valid_q;
      out_word_d = out_word_q;
      out_bytes_d = out_bytes_q;
`ifdef REQUANT_PER_CHANNEL_EN
      ch_d = ch_q;
`endif
      // A negative shift is a right shift deferred to S4; positive shifts happen here.
      x = (in_acc + sel_bias) << (sel_shift[5] ? 6'd0 : sel_shift);
      xs = {{32{s1_x_q[31]}}, s1_x_q};
      ms = {{32{s1_mult_q[31]}}, s1_mult_q};
      t = s2_p_q + (s2_p_q[63] ? NUDGE_NEG : NUDGE_POS);
      q = $signed(t + (t[63] ? 64'h7FFF_FFFF : 64'd0)) >>> 31;
      e = s3_shift_q[5] ? (6'd0 - s3_shift_q) : 6'd0;
      mask = (32'd1 << e) - 32'd1;
      thr = (mask >> 1) + {31'd0, s3_y_q[31]};
      r = ($signed(s3_y_q) >>> e) + (((s3_y_q & mask) > thr) ? 32'sd1 : 32'sd0);
      v = r + $signed(ofs_q);
      clamped = (v < $signed(amin_q)) ? amin_q : ((v > $signed(amax_q)) ? amax_q : v);
      word = {8'd0, pack_q} | (32'(s4_byte_q) << (cnt_q * BYTE_SIZE));
      if (en) begin
         {s1_v_d, s1_last_d, s1_x_d, s1_mult_d, s1_shift_d} = {in_valid, in_last, x, sel_mult, sel_shift};
         s2_v_d = s1_v_q;
         s2_last_d = s1_last_q;
         s2_p_d = xs * ms;
         s2_sat_d = (s1_x_q == INT_MIN) && (s1_mult_q == INT_MIN);
         s2_shift_d = s1_shift_q;
         s3_v_d = s2_v_q;
         s3_last_d = s2_last_q;
         s3_y_d = s2_sat_q ? 32'h7FFF_FFFF : q[31:0];
         s3_shift_d = s2_shift_q;
         {s4_v_d, s4_last_d, s4_byte_d} = {s3_v_q, s3_last_q, clamped[BYTE_SIZE-1:0]};
         // en implies any held word is being drained this edge.
         out_valid_d = 1'b0;
         if (s4_v_q) begin
            if (cnt_q == 2'd3 || s4_last_q) begin
               out_word_d = word;
               out_bytes_d = {1'b0, cnt_q} + 3'd1;
               out_valid_d = 1'b1;
               pack_d = 24'd0;
               cnt_d = 2'd0;
            end else begin
               pack_d = word[23:0];
               cnt_d = cnt_q + 2'd1;
            end
         end
`ifdef REQUANT_PER_CHANNEL_EN
         if (in_valid)
            ch_d = (in_last || ({1'b0, ch_q} + 8'd1 >= chan_cnt_q)) ? 7'd0 : ch_q + 7'd1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
`ifdef REQUANT_PER_CHANNEL_EN
         bias_q <= '0;
         mult_q <= {MAX_CHANNELS{MULT_RST}};
         shift_q <= '0;
         chan_cnt_q <= 8'd1;
         ch_q <= 7'd0;
`else
         bias_q <= '0;
         mult_q <= MULT_RST;
         shift_q <= '0;
`endif
         ofs_q <= '0;
         amin_q <= ACT_MIN_RST;
         amax_q <= ACT_MAX_RST;
         {s1_v_q, s1_last_q, s1_x_q, s1_mult_q, s1_shift_q} <= '0;
         {s2_v_q, s2_last_q, s2_sat_q, s2_p_q, s2_shift_q} <= '0;
         {s3_v_q, s3_last_q, s3_y_q, s3_shift_q} <= '0;
         {s4_v_q, s4_last_q, s4_byte_q} <= '0;
         pack_q <= '0;
         cnt_q <= '0;
         out_valid_q <= 1'b0;
         out_word_q <= '0;
         out_bytes_q <= '0;
      end else begin
`ifdef REQUANT_PER_CHANNEL_EN
         chan_cnt_q <= chan_cnt_d;
         ch_q <= ch_d;
`endif
         bias_q <= bias_d;
         mult_q <= mult_d;
         shift_q <= shift_d;
         ofs_q <= ofs_d;
         amin_q <= amin_d;
         amax_q <= amax_d;
         {s1_v_q, s1_last_q, s1_x_q, s1_mult_q, s1_shift_q} <= {s1_v_d, s1_last_d, s1_x_d, s1_mult_d, s1_shift_d};
         {s2_v_q, s2_last_q, s2_sat_q, s2_p_q, s2_shift_q} <= {s2_v_d, s2_last_d, s2_sat_d, s2_p_d, s2_shift_d};
         {s3_v_q, s3_last_q, s3_y_q, s3_shift_q} <= {s3_v_d, s3_last_d, s3_y_d, s3_shift_d};
         {s4_v_q, s4_last_q, s4_byte_q} <= {s4_v_d, s4_last_d, s4_byte_d};
         pack_q <= pack_d;
         cnt_q <= cnt_d;
         out_valid_q <= out_valid_d;
         out_word_q <= out_word_d;
         out_bytes_q <= out_bytes_d;
      end
   end

   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out_word  = out_word_q;
   assign out_bytes = out_bytes_q;
   assign busy      = s1_v_q | s2_v_q | s3_v_q | s4_v_q | (cnt_q != 2'd0) | out_valid_q;

endmodule
`default_nettype wire

// File: doc/conv1d_requant_pack.md
# conv1d_requant_pack

Output stage placed directly downstream of `conv1d`. It accepts the raw int32 accumulator of each finished output point and applies the TFLite int8 requantization chain: bias add, quantized-multiplier scaling, rounding shift, output offset and activation clamp. It then packs four consecutive int8 results into one little-endian 32-bit word for readback by the CPU through the CFU response path.

## Interface
- `BYTE_SIZE`, 8, width of one packed result
- `INT32_SIZE`, 32, accumulator/config/word width
- `MAX_CHANNELS`, 128, per-channel table depth (used only with the configuration macro)
- `clk` input 1: single clock
- `reset` input 1: synchronous, active-high; clears pipeline, packer, counters and config registers
- `cfg_we` input 1: config write strobe
- `cfg_addr` input 3: 0 bias, 1 multiplier, 2 shift (signed, [5:0]), 3 output_offset, 4 act_min, 5 act_max, 6 channel_count
- `cfg_index` input 7: per-channel table index
- `cfg_data` input 32: config write data
- `in_valid` input 1: `in_acc` is valid
- `in_ready` output 1: stage accepts an accumulator this cycle
- `in_acc` input 32: signed accumulator from `conv1d`
- `in_last` input 1: accompanies `in_acc`; flush the word after this byte
- `out_valid` output 1: `out_word` is valid
- `out_ready` input 1: consumer takes the word
- `out_word` output 32: byte0 = oldest result; unused bytes are 0
- `out_bytes` output 3: count of valid bytes in `out_word` (1..4)
- `busy` output 1: any pipeline stage valid, packer non-empty, or `out_valid`

## Operation
- Transfers occur on `in_valid && in_ready` and `out_valid && out_ready`.
- Global enable `en = !out_valid || out_ready`; `in_ready = en`. All stages advance only when `en` is high. The pipeline never drops an item.
- S1: `x = in_acc + bias` (32-bit wrap), then `x = x << max(shift,0)` (32-bit wrap).
- S2: `p = x * multiplier`, signed 64-bit.
- S3: SRDHM. Add nudge (`p>=0 ? 2^30 : 1-2^30`), then divide by 2^31 truncating toward zero. If `x == multiplier == 0x80000000`, the result is `0x7FFFFFFF`.
- S4: rounding divide by 2^e, with `e = max(-shift,0)`.
  - `mask = 2^e-1`, `rem = y & mask`, `thr = (mask>>1) + (y<0)`.
  - `r = (y>>>e) + (rem>thr)`.
  - Then add `output_offset` and clamp to [act_min, act_max]. Low 8 bits go to the packer.
- Packer: holds 0..3 bytes plus a byte counter. On the 4th byte, or on a byte tagged `in_last`, it loads `out_word`/`out_bytes`, sets `out_valid` and empties itself.
- `in_last` resets the channel counter to 0.
- Config reset values: bias 0, multiplier 0x40000000, shift 0, output_offset 0, act_min -128, act_max 127, channel_count 1.
- Config writes while `busy`=1 are illegal; the effect on in-flight items is undefined.
- Shift values outside -31..30 are illegal.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_word`=0, `out_bytes`=0, `busy`=0.
- Latency: with the input accepted at edge k, the result byte is registered at edge k+3. The packer loads `out_word` at edge k+4.
- Four back-to-back inputs at edges 0..3 raise `out_valid` after edge 7.
- `out_valid` and `out_word` are held stable until `out_ready`. The next word may be loaded on the same edge that drains the current one.
- Throughput is 1 accumulator/cycle while `out_ready`=1.
- Reset mid-operation discards all in-flight bytes and any held word on the next edge.

## Configuration
- Macro `REQUANT_PER_CHANNEL_EN`.
  - Defined: bias, multiplier and shift are `MAX_CHANNELS`-entry tables written at `cfg_index`.
  - S1 reads entry `ch`. `ch` increments per accepted input and wraps at channel_count.
  - Reset clears all table entries to the scalar reset values.
- Undefined: `cfg_index` and channel_count are ignored, and single scalar registers are used.

## Test plan
- Defaults; acc 10, 20, -10, 300 back-to-back -> `out_word`=0x7FFB0A05, `out_bytes`=4, `out_valid` after edge 7.
- shift=-1; acc 6, then -6 with `in_last` -> `out_word`=0x0000FE02, `out_bytes`=2.
- multiplier=0x80000000, output_offset=-128; acc 0x80000000 -> saturation, byte 0x7F; acc 0 -> byte 0x80 (-128).
- 8 accs streamed with `out_ready`=0 for 10 cycles -> `in_ready` low while stalled; 2 words delivered in order with no loss or duplication.
- 3 accs accepted, then `reset` pulse -> `out_valid`=0, `busy`=0, config back to defaults; next 4 accs produce one fresh word.
- With `REQUANT_PER_CHANNEL_EN`: channel_count=2, ch1 multiplier 0x20000000; acc 40, 40, 40, 40 -> `out_word`=0x0A140A14.
